// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned NIBBLE_W    = 4;
    localparam logic [3:0]  ADD3_THRESH = 4'd5;

    // Number of decimal digits needed to show 2**width-1
    function automatic int unsigned digits_needed(input int unsigned width);
        logic [63:0] max_v;
        int unsigned n;
        max_v = (64'd1 << width) - 64'd1;
        n     = 32'd1;
        while (max_v >= 64'd10) begin
            max_v = max_v / 64'd10;
            n     = n + 32'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle for bin2bcd_seq; the blank flags exist only when
// BIN2BCD_BLANK_EN is defined.
interface bin2bcd_seq_if
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
);

    logic                         start;
    logic [WIDTH-1:0]             bin_in;
    logic                         busy;
    logic                         done;
    logic [NIBBLE_W*DIGITS-1:0]   bcd_out;
`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]            blank;

    modport master (output start, bin_in, input busy, done, bcd_out, blank);
    modport slave  (input start, bin_in, output busy, done, bcd_out, blank);
`else
    modport master (output start, bin_in, input busy, done, bcd_out);
    modport slave  (input start, bin_in, output busy, done, bcd_out);
`endif

endinterface

// File: rtl/dabble_adj.sv
// Single-digit add-3 corrector applied to each BCD nibble before the left shift.
module dabble_adj
    import bcd_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nib_i,
    output logic [NIBBLE_W-1:0] nib_o
);

    // A nibble of 5..9 becomes 8..12 so doubling carries into the next digit
    always_comb begin
        if (nib_i >= ADD3_THRESH) begin
            nib_o = nib_i + 4'd3;
        end else begin
            nib_o = nib_i;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift per clock with start/busy/done handshake.
// Optional leading-zero blank flags are built when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic          clk,
    input  logic          reset,
    bin2bcd_seq_if.slave  bus
);

    localparam int unsigned      ACC_W    = NIBBLE_W * DIGITS;
    localparam int unsigned      CNT_W    = $clog2(WIDTH + 32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    if (DIGITS < digits_needed(WIDTH)) begin : g_digits_check
        $error("bin2bcd_seq: DIGITS too small to hold 2**WIDTH-1");
    end

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    bin_sr_q, bin_sr_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    bcd_q, bcd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ACC_W-1:0]    adj_s;
    logic [ACC_W+WIDTH-1:0] shifted_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        dabble_adj u_adj (
            .nib_i (acc_q[g*NIBBLE_W +: NIBBLE_W]),
            .nib_o (adj_s[g*NIBBLE_W +: NIBBLE_W])
        );
    end

    assign shifted_s = {adj_s, bin_sr_q} << 1'b1;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d, blank_s;
    logic              nz_s;

    // Digit i is blank while it and every higher digit are zero; digit 0 always shows
    always_comb begin
        blank_s = '0;
        nz_s    = 1'b0;
        for (int i = int'(DIGITS) - 32'sd1; i >= 32'sd1; i--) begin
            nz_s       = nz_s | (acc_q[i*NIBBLE_W +: NIBBLE_W] != 4'd0);
            blank_s[i] = ~nz_s;
        end
    end
`endif

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bin_sr_d = bin_sr_q;
        acc_d    = acc_q;
        bcd_d    = bcd_q;
`ifdef BIN2BCD_BLANK_EN
        blank_d  = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = SHIFT;
                    bin_sr_d = bus.bin_in;
                    acc_d    = '0;
                    cnt_d    = '0;
                end else begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                // The counter reaching WIDTH means all bits are in; publish the accumulator
                if (cnt_q == CNT_LAST) begin
                    bcd_d   = acc_q;
`ifdef BIN2BCD_BLANK_EN
                    blank_d = blank_s;
`endif
                    state_d = DONE;
                end else begin
                    {acc_d, bin_sr_d} = shifted_s;
                    cnt_d             = cnt_q + CNT_W'(1'b1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bin_sr_q <= '0;
            acc_q    <= '0;
            bcd_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
            blank_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bin_sr_q <= bin_sr_d;
            acc_q    <= acc_d;
            bcd_q    <= bcd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef BIN2BCD_BLANK_EN
            blank_q  <= blank_d;
`endif
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_q;
`ifdef BIN2BCD_BLANK_EN
    assign bus.blank   = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq (WIDTH=8, DIGITS=3); blank checks run when
// BIN2BCD_BLANK_EN is defined.
module tb_bin2bcd_seq;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DIGITS = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_pulses = 0;
    logic [11:0] exp_q[$];
    logic [11:0] last_bcd;

    function automatic logic [11:0] bcd_ref(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 30) begin
            tick();
            n++;
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_wait: busy=%b required 0", bus.busy);
        end
    endtask

    // Waits for done after an accept; returns cycles elapsed and whether it arrived
    task automatic wait_done(input bit chk_stable, output int lat, output bit got);
        got = 1'b0;
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (bus.done === 1'b1) begin
                got = 1'b1;
                lat = n;
                break;
            end
            if (chk_stable) begin
                n_cmp++;
                if (bus.bcd_out !== last_bcd) begin
                    n_bad++;
                    $display("FAIL bcd_stable: bcd_out=%h required %h", bus.bcd_out, last_bcd);
                end
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL done_timeout: done=%b required 1 within 30 cycles", bus.done);
        end
    endtask

    task automatic check_result(input string tag);
        logic [11:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s_scoreboard: done with empty queue, bcd_out=%h", tag, bus.bcd_out);
        end else begin
            e = exp_q.pop_front();
            if (bus.bcd_out !== e) begin
                n_bad++;
                $display("FAIL %s_result: bcd_out=%h required %h", tag, bus.bcd_out, e);
            end
            last_bcd = e;
        end
        done_pulses++;
    endtask

    task automatic do_conv(input logic [7:0] v);
        int lat;
        bit got;
        wait_idle();
        bus.bin_in = v;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        exp_q.push_back(bcd_ref(int'(v)));
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_accept: busy=%b required 1 (bin_in=%0d)", bus.busy, v);
        end
        wait_done(1'b1, lat, got);
        if (got) begin
            n_cmp++;
            if (lat != int'(WIDTH) + 1) begin
                n_bad++;
                $display("FAIL latency: done after %0d cycles required %0d", lat, WIDTH + 1);
            end
            check_result("conv");
            n_cmp++;
            if (bus.busy !== 1'b1) begin
                n_bad++;
                $display("FAIL busy_in_done: busy=%b required 1", bus.busy);
            end
            tick();
            n_cmp++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL done_single: done=%b busy=%b required 0 0", bus.done, bus.busy);
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_out !== 12'h000) begin
            n_bad++;
            $display("FAIL %s: busy=%b done=%b bcd_out=%h required 0 0 000",
                     tag, bus.busy, bus.done, bus.bcd_out);
        end
`ifdef BIN2BCD_BLANK_EN
        n_cmp++;
        if (bus.blank !== 3'b000) begin
            n_bad++;
            $display("FAIL %s_blank: blank=%b required 000", tag, bus.blank);
        end
`endif
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = 8'd0;
        repeat (3) tick();
        reset      = 1'b0;
        tick();
        last_bcd = 12'h000;
        check_cleared("reset_state");
    endtask

    task automatic test_max_value();
        do_conv(8'd255);
    endtask

    task automatic test_boundaries();
        do_conv(8'd0);
        do_conv(8'd99);
        do_conv(8'd100);
        do_conv(8'd1);
    endtask

    task automatic test_sweep();
        int p0;
        p0 = done_pulses;
        for (int v = 0; v < 256; v++) begin
            do_conv(8'(v));
        end
        n_cmp++;
        if (done_pulses - p0 != 256) begin
            n_bad++;
            $display("FAIL sweep_pulses: %0d done pulses required 256", done_pulses - p0);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        bit got;
        wait_idle();
        bus.bin_in = 8'd42;
        bus.start  = 1'b1;
        tick();
        exp_q.push_back(bcd_ref(42));
        bus.bin_in = 8'd200;
        repeat (3) tick();
        bus.start  = 1'b0;
        wait_done(1'b1, lat, got);
        if (got) begin
            n_cmp++;
            if (lat != int'(WIDTH) + 1 - 3) begin
                n_bad++;
                $display("FAIL ignore_latency: done %0d cycles after release required %0d", lat, WIDTH - 2);
            end
            check_result("ignore");
        end
        repeat (4) tick();
        n_cmp++;
        if (bus.busy !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL ignore_no_second: busy=%b queue=%0d required 0 0", bus.busy, exp_q.size());
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        wait_idle();
        bus.bin_in = 8'd255;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_bcd = 12'h000;
        check_cleared("abort_state");
        pulses = 0;
        for (int n = 0; n < 14; n++) begin
            if (bus.done === 1'b1) pulses++;
            tick();
        end
        n_cmp++;
        if (pulses != 0 || bus.busy !== 1'b0 || bus.bcd_out !== 12'h000) begin
            n_bad++;
            $display("FAIL abort_quiet: pulses=%0d busy=%b bcd_out=%h required 0 0 000",
                     pulses, bus.busy, bus.bcd_out);
        end
        do_conv(8'd7);
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3];
        int lat;
        bit got;
        vals[0] = 8'd13;
        vals[1] = 8'd250;
        vals[2] = 8'd128;
        wait_idle();
        bus.bin_in = vals[0];
        bus.start  = 1'b1;
        tick();
        exp_q.push_back(bcd_ref(int'(vals[0])));
        for (int k = 0; k < 3; k++) begin
            wait_done(1'b0, lat, got);
            if (got) check_result("b2b");
            if (k < 2) begin
                bus.bin_in = vals[k + 1];
                exp_q.push_back(bcd_ref(int'(vals[k + 1])));
            end else begin
                bus.start = 1'b0;
            end
        end
        repeat (2) tick();
        n_cmp++;
        if (bus.busy !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_drain: busy=%b queue=%0d required 0 0", bus.busy, exp_q.size());
        end
    endtask

`ifdef BIN2BCD_BLANK_EN
    task automatic blank_case(input logic [7:0] v, input logic [2:0] exp_blank);
        do_conv(v);
        n_cmp++;
        if (bus.blank !== exp_blank) begin
            n_bad++;
            $display("FAIL blank_%0d: blank=%b required %b", v, bus.blank, exp_blank);
        end
    endtask

    task automatic test_blank();
        blank_case(8'd7,   3'b110);
        blank_case(8'd42,  3'b100);
        blank_case(8'd0,   3'b110);
        blank_case(8'd130, 3'b000);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_max_value();
        test_boundaries();
        test_sweep();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
`ifdef BIN2BCD_BLANK_EN
        test_blank();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
